// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared defaults, derived widths and sequencer state encoding
package systolic_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ACC_W      = 8;
  localparam int DEF_MAC_LAT    = 4;
  localparam int DEF_ROWS_W     = 8;

  localparam int DEF_VEC_W = DEF_ARRAY_SIZE * DEF_DATA_W;
  localparam int DEF_WGT_W = DEF_ARRAY_SIZE * DEF_ARRAY_SIZE * DEF_DATA_W;
  localparam int DEF_RES_W = DEF_ARRAY_SIZE * DEF_ACC_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// rtl/systolic_seq_ctrl_if.sv - activation input stream and aligned result stream
interface systolic_seq_ctrl_if
  import systolic_pkg::*;
#(
  parameter int VEC_W = DEF_VEC_W,
  parameter int RES_W = DEF_RES_W
);

  logic             act_valid;
  logic             act_ready;
  logic [VEC_W-1:0] act_data;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic             res_last;

  modport master (
    output act_valid, act_data,
    input  act_ready, res_valid, res_data, res_last
  );

  modport slave (
    input  act_valid, act_data,
    output act_ready, res_valid, res_data, res_last
  );

endinterface

// File: rtl/lane_delay.sv
// rtl/lane_delay.sv - fixed-depth register delay line with synchronous clear
module lane_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ clear;
    assign dout        = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (clear) begin
        for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else begin
        stage[0] <= din;
        for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - skews activation vectors into a systolic array and
// de-skews its column outputs into one aligned result per accepted vector
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int MAC_LAT    = DEF_MAC_LAT,
  parameter int ROWS_W     = DEF_ROWS_W
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [ROWS_W-1:0]                      cfg_rows,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] cfg_weight,
  output logic                                   busy,
  output logic                                   done,
  systolic_seq_ctrl_if.slave                     io,
  output logic [ARRAY_SIZE*DATA_W-1:0]           sa_datain,
  output logic [ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] sa_weightin,
  input  logic [ARRAY_SIZE*ACC_W-1:0]            sa_macout
);

  localparam int VW     = ARRAY_SIZE * DATA_W;
  localparam int WW     = ARRAY_SIZE * ARRAY_SIZE * DATA_W;
  localparam int RW     = ARRAY_SIZE * ACC_W;
  localparam int PIPE_D = MAC_LAT + ARRAY_SIZE;
  localparam logic [ROWS_W-1:0] ROWS_ONE = ROWS_W'(1);

  seq_state_e        state_q, state_d;
  logic [ROWS_W-1:0] n_rows, acc_cnt, res_cnt, last_idx;
  logic [WW-1:0]     weight_q;
  logic [VW-1:0]     launch_q;
  logic [PIPE_D-1:0] vpipe;
  logic              res_valid_q;
  logic [RW-1:0]     res_data_q;
  logic [RW-1:0]     aligned;
  logic              act_ready, accept, res_last, take_job;

  assign accept   = io.act_valid && act_ready;
  assign take_job = (state_q == ST_IDLE) && start && (cfg_rows != '0);
  assign last_idx = n_rows - ROWS_ONE;
  assign res_last = res_valid_q && (res_cnt == last_idx);

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    act_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (cfg_rows != '0) ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: state_d = ST_FEED;
      ST_FEED: begin
        act_ready = 1'b1;
        if (io.act_valid && (acc_cnt == last_idx)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (res_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      n_rows      <= '0;
      acc_cnt     <= '0;
      res_cnt     <= '0;
      weight_q    <= '0;
      launch_q    <= '0;
      vpipe       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept)      acc_cnt <= acc_cnt + ROWS_ONE;
      if (res_valid_q) res_cnt <= res_cnt + ROWS_ONE;
      if (take_job) begin
        weight_q <= cfg_weight;
        n_rows   <= cfg_rows;
        acc_cnt  <= '0;
        res_cnt  <= '0;
      end
      // Lane 0 launches straight from this register; bubbles launch zeros.
      launch_q    <= accept ? io.act_data : '0;
      vpipe       <= {vpipe[PIPE_D-2:0], accept};
      res_valid_q <= vpipe[PIPE_D-1];
      if (vpipe[PIPE_D-1]) res_data_q <= aligned;
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_skew
    lane_delay #(.WIDTH(DATA_W), .DEPTH(i)) u_skew (
      .clk   (clk),
      .clear (reset),
      .din   (launch_q[DATA_W*i +: DATA_W]),
      .dout  (sa_datain[DATA_W*i +: DATA_W])
    );
  end

  // Column j arrives j cycles after column 0; delaying it by the complement lines all up.
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_deskew
    lane_delay #(.WIDTH(ACC_W), .DEPTH(ARRAY_SIZE-1-j)) u_deskew (
      .clk   (clk),
      .clear (reset),
      .din   (sa_macout[ACC_W*j +: ACC_W]),
      .dout  (aligned[ACC_W*j +: ACC_W])
    );
  end

  assign sa_weightin  = weight_q;
  assign io.act_ready = act_ready;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_last  = res_last;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - directed bench for systolic_seq_ctrl with a behavioural array model
module tb_systolic_seq_ctrl;
  import systolic_pkg::*;

  localparam int ML = 4;
  localparam logic [127:0] W1 = 128'h100f0e0d0c0b0a090807060504030201;
  localparam logic [127:0] W2 = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  localparam logic [127:0] W3 = 128'hdeadbeef_cafef00d_01234567_89abcdef;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   cfg_rows = '0;
  logic [127:0] cfg_weight = '0;
  logic         busy, done;
  logic [31:0]  sa_datain;
  logic [127:0] sa_weightin;
  logic [31:0]  sa_macout = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  bit   [31:0] hist [64];
  logic [31:0] vec_tbl [8];
  logic [31:0] res_tbl [8];
  logic [31:0] sa_tbl  [16];

  systolic_seq_ctrl_if io ();

  systolic_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_rows    (cfg_rows),
    .cfg_weight  (cfg_weight),
    .busy        (busy),
    .done        (done),
    .io          (io),
    .sa_datain   (sa_datain),
    .sa_weightin (sa_weightin),
    .sa_macout   (sa_macout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Column j in cycle c reflects the vector launched at c-ML-j, lane i taken from cycle c-ML-j+i.
  always @(negedge clk) begin
    logic [7:0] s;
    hist[cyc % 64] = sa_datain;
    for (int j = 0; j < 4; j++) begin
      s = 8'(j + 1);
      for (int i = 0; i < 4; i++)
        if (cyc - ML - j + i >= 0) s = s + hist[(cyc - ML - j + i) % 64][8*i +: 8];
      sa_macout[8*j +: 8] = s;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input int n, input logic [127:0] w, input logic [31:0] vpat,
                         input int npat, input logic [31:0] rv_mask, input int done_k,
                         input bit sa_chk, input int sk1, input int sk2);
    int acc;
    int ridx;
    acc  = 0;
    ridx = 0;
    start = 1'b1;
    cfg_rows = n[7:0];
    cfg_weight = w;
    @(negedge clk);
    start = 1'b0;
    cfg_rows = 8'd77;
    cfg_weight = W3;
    check("load_busy", busy, 1);
    check("load_ready", io.act_ready, 0);
    check("load_wgt", sa_weightin, w);
    @(negedge clk);
    for (int k = 0; k <= done_k + 1; k++) begin
      bit rv_exp;
      rv_exp = rv_mask[k];
      check($sformatf("k%0d_ready", k), io.act_ready, acc < n);
      check($sformatf("k%0d_rvalid", k), io.res_valid, rv_exp);
      if (rv_exp) begin
        check($sformatf("k%0d_rdata", k), io.res_data, res_tbl[ridx]);
        check($sformatf("k%0d_rlast", k), io.res_last, ridx == n - 1);
        ridx++;
      end
      if (k == done_k && ridx > 0) check("rdata_hold", io.res_data, res_tbl[ridx-1]);
      check($sformatf("k%0d_done", k), done, k == done_k);
      check($sformatf("k%0d_busy", k), busy, k <= done_k);
      if (sa_chk) check($sformatf("k%0d_sa", k), sa_datain, sa_tbl[k]);
      io.act_valid = (k < npat) && vpat[k];
      io.act_data  = io.act_valid ? vec_tbl[acc] : 32'hdeadbeef;
      if (io.act_valid && acc < n) acc++;
      start = (k == sk1) || (k == sk2);
      if (start) begin
        cfg_weight = W3;
        cfg_rows = 8'd3;
      end
      @(negedge clk);
    end
    io.act_valid = 1'b0;
    start = 1'b0;
    check("wgt_hold", sa_weightin, w);
  endtask

  initial begin
    int nrv, ndn, nacc, nlast, last_pos;
    io.act_valid = 1'b0;
    io.act_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", io.act_ready, 0);
    check("rst_sa", sa_datain, 0);
    check("rst_wgt", sa_weightin, 0);
    check("rst_rvalid", io.res_valid, 0);
    check("rst_rdata", io.res_data, 0);
    check("rst_rlast", io.res_last, 0);
    reset = 1'b0;
    @(negedge clk);

    // single vector: skew and alignment
    for (int k = 0; k < 16; k++) sa_tbl[k] = 32'h0;
    sa_tbl[1] = 32'h00000001;
    sa_tbl[2] = 32'h00000200;
    sa_tbl[3] = 32'h00030000;
    sa_tbl[4] = 32'h04000000;
    vec_tbl[0] = 32'h04030201;
    res_tbl[0] = 32'h0e0d0c0b;
    run_job(1, W1, 32'h1, 1, 32'h200, 10, 1'b1, -1, -1);

    // zero-length job
    start = 1'b1;
    cfg_rows = 8'd0;
    cfg_weight = W2;
    @(negedge clk);
    start = 1'b0;
    check("zero_busy", busy, 1);
    check("zero_done", done, 1);
    check("zero_wgt", sa_weightin, W1);
    check("zero_rvalid", io.res_valid, 0);
    @(negedge clk);
    check("zero_busy_after", busy, 0);
    check("zero_done_after", done, 0);

    // back-to-back with bubbles, N=5, pattern 1,1,0,1,0,0,1,1
    vec_tbl[0] = 32'h01010101; res_tbl[0] = 32'h08070605;
    vec_tbl[1] = 32'h02020202; res_tbl[1] = 32'h0c0b0a09;
    vec_tbl[2] = 32'h10000000; res_tbl[2] = 32'h14131211;
    vec_tbl[3] = 32'h00000003; res_tbl[3] = 32'h07060504;
    vec_tbl[4] = 32'h20100804; res_tbl[4] = 32'h403f3e3d;
    run_job(5, W2, 32'hcb, 8, 32'h19600, 17, 1'b0, -1, -1);

    // reset two cycles after the second accept
    start = 1'b1;
    cfg_rows = 8'd4;
    cfg_weight = W1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    io.act_valid = 1'b1;
    io.act_data = 32'h01010101;
    @(negedge clk);
    io.act_data = 32'h02020202;
    @(negedge clk);
    io.act_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", io.act_ready, 0);
    check("abort_sa", sa_datain, 0);
    check("abort_wgt", sa_weightin, 0);
    check("abort_rvalid", io.res_valid, 0);
    check("abort_rdata", io.res_data, 0);
    check("abort_rlast", io.res_last, 0);
    nrv = 0;
    ndn = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (io.res_valid) nrv++;
      if (done) ndn++;
    end
    check("abort_no_rvalid", nrv, 0);
    check("abort_no_done", ndn, 0);

    // recovery job, then start pulses during FEED and DONE
    vec_tbl[0] = 32'h01010101; res_tbl[0] = 32'h08070605;
    vec_tbl[1] = 32'h02020202; res_tbl[1] = 32'h0c0b0a09;
    run_job(2, W1, 32'h3, 2, 32'h600, 11, 1'b0, -1, -1);
    run_job(2, W2, 32'h3, 2, 32'h600, 11, 1'b0, 0, 11);

    // maximum row count, continuous stream
    start = 1'b1;
    cfg_rows = 8'd255;
    cfg_weight = W1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    io.act_valid = 1'b1;
    io.act_data = 32'h00000101;
    nacc = 0; nrv = 0; nlast = 0; last_pos = 0; ndn = 0;
    for (int k = 0; k < 300; k++) begin
      if (io.act_ready) nacc++;
      if (io.res_valid) begin
        nrv++;
        if (io.res_last) begin
          nlast++;
          last_pos = nrv;
        end
      end
      if (done) ndn++;
      @(negedge clk);
    end
    io.act_valid = 1'b0;
    check("max_accepts", nacc, 255);
    check("max_results", nrv, 255);
    check("max_last_cnt", nlast, 1);
    check("max_last_pos", last_pos, 255);
    check("max_done", ndn, 1);
    check("max_busy", busy, 0);
    check("max_rdata", io.res_data, 32'h06050403);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
